// File: rtl/ripple_mon_pkg.sv
// Shared types and helpers for the ripple counter monitor.
package ripple_mon_pkg;

    typedef enum logic {INIT, RUN} mon_state_t;

    // Modular difference; callers truncate the result to their counter width.
    function automatic logic [31:0] mod_delta(input logic [31:0] a, input logic [31:0] b);
        return a - b;
    endfunction

endpackage

// File: rtl/ripple_count_monitor_sync_stage.sv
// Plain multi-flop synchroniser with synchronous active-low reset.
module sync_stage #(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_nrst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_chain [DEPTH];

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_chain[i] <= '0;
            end
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[DEPTH-1];

endmodule

// File: rtl/ripple_count_monitor.sv
// Resynchronises a ripple counter, filters transients and accumulates its deltas.
module ripple_count_monitor
    import ripple_mon_pkg::*;
#(
    parameter int unsigned CW   = 3,
    parameter int unsigned AW   = 16,
    parameter int unsigned SYNC = 2,
    parameter int unsigned MAXD = 2 ** (CW - 1)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic [CW-1:0] cnt_in,
    input  logic          clr,
    input  logic [AW-1:0] thr,
    input  logic          thr_ld,
    output logic [AW-1:0] total,
    output logic          valid,
    output logic          hit,
    output logic          ovf,
    output logic          err
);

    localparam int unsigned SW = AW + 1;

    logic [CW-1:0] w_s;
    logic [CW-1:0] w_d;
    logic [SW-1:0] w_sum;
    logic [AW-1:0] w_total_nx;
    logic          w_accept;
    logic          w_add;

    logic [CW-1:0] r_prev;
    logic [CW-1:0] r_last;
    logic [AW-1:0] r_total;
    logic [AW-1:0] r_thr;
    logic [SYNC:0] r_fill;
    logic          r_valid;
    logic          r_hit;
    logic          r_ovf;
    logic          r_err;
    mon_state_t    r_state;

    sync_stage #(
        .W     (CW),
        .DEPTH (SYNC)
    ) u_sync (
        .i_clk  (clk),
        .i_nrst (nrst),
        .i_d    (cnt_in),
        .o_q    (w_s)
    );

    // Accept only once the sync chain and prev hold post-reset samples.
    always_comb begin
        w_accept   = r_fill[SYNC] && (w_s == r_prev);
        w_add      = (r_state == RUN) && w_accept;
        w_d        = CW'(mod_delta(32'(w_s), 32'(r_last)));
        w_sum      = {1'b0, r_total} + SW'(w_d);
        w_total_nx = w_add ? w_sum[AW-1:0] : r_total;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= INIT;
            r_fill  <= '0;
            r_prev  <= '0;
            r_last  <= '0;
            r_total <= '0;
            r_thr   <= '1;
            r_valid <= 1'b0;
            r_hit   <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_fill <= {r_fill[SYNC-1:0], 1'b1};
            r_prev <= w_s;
            if (thr_ld) begin
                r_thr <= thr;
            end
            if (clr) begin
                r_total <= '0;
                r_hit   <= 1'b0;
                r_ovf   <= 1'b0;
                r_err   <= 1'b0;
                if (w_add) begin
                    r_last <= w_s;
                end
            end else begin
                case (r_state)
                    INIT: begin
                        if (w_accept) begin
                            r_last  <= w_s;
                            r_valid <= 1'b1;
                            r_state <= RUN;
                        end
                    end
                    RUN: begin
                        if (w_accept) begin
                            r_last  <= w_s;
                            r_total <= w_sum[AW-1:0];
                            if (w_sum[AW]) begin
                                r_ovf <= 1'b1;
                            end
                            if (32'(w_d) > MAXD) begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= INIT;
                endcase
                r_hit <= r_hit | (w_total_nx >= r_thr);
            end
        end
    end

    assign total = r_total;
    assign valid = r_valid;
    assign hit   = r_hit;
    assign ovf   = r_ovf;
    assign err   = r_err;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed self-checking bench for ripple_count_monitor (default and AW=4 instances).
module tb_ripple_count_monitor;

    logic        clk = 1'b0;
    logic        nrst;
    logic [2:0]  cnt_in;
    logic        clr;
    logic [15:0] thr;
    logic        thr_ld;
    logic [15:0] total;
    logic        valid, hit, ovf, err;

    logic [2:0]  cnt_in2;
    logic        clr2;
    logic [3:0]  thr2;
    logic        thr_ld2;
    logic [3:0]  total2;
    logic        valid2, hit2, ovf2, err2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ripple_count_monitor dut (
        .clk    (clk),
        .nrst   (nrst),
        .cnt_in (cnt_in),
        .clr    (clr),
        .thr    (thr),
        .thr_ld (thr_ld),
        .total  (total),
        .valid  (valid),
        .hit    (hit),
        .ovf    (ovf),
        .err    (err)
    );

    ripple_count_monitor #(
        .AW (4)
    ) dut4 (
        .clk    (clk),
        .nrst   (nrst),
        .cnt_in (cnt_in2),
        .clr    (clr2),
        .thr    (thr2),
        .thr_ld (thr_ld2),
        .total  (total2),
        .valid  (valid2),
        .hit    (hit2),
        .ovf    (ovf2),
        .err    (err2)
    );

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0; cnt_in = 3'd5; clr = 1'b0; thr = '0; thr_ld = 1'b0;
        cnt_in2 = 3'd0; clr2 = 1'b0; thr2 = '0; thr_ld2 = 1'b0;
        tick(3);
        n_tests++;
        if ({valid, hit, ovf, err} !== 4'b0000 || total !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v/h/o/e=%b total=%0d, want 0000 total=0",
                     {valid, hit, ovf, err}, total);
        end
        nrst = 1'b1;
        tick(3);
        n_tests++;
        if (valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid_early: got %b want 0", valid);
        end
        tick(1);
        n_tests++;
        if (valid !== 1'b1 || total !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_valid_4th: got valid=%b total=%0d want 1/0", valid, total);
        end
    endtask

    task automatic test_walk();
        logic [2:0] seq [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
        for (int i = 0; i < 4; i++) begin
            cnt_in = seq[i];
            tick(3);
            n_tests++;
            if (total !== 16'(i)) begin
                n_fail++; $display("FAIL walk_pre%0d: got %0d want %0d", i, total, i);
            end
            tick(1);
            n_tests++;
            if (total !== 16'(i + 1)) begin
                n_fail++; $display("FAIL walk_step%0d: got %0d want %0d", i, total, i + 1);
            end
        end
        n_tests++;
        if (ovf !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL walk_flags: got ovf=%b err=%b want 0/0", ovf, err);
        end
    endtask

    task automatic test_glitch();
        cnt_in = 3'd3;
        tick(1);
        cnt_in = 3'd1;
        tick(6);
        n_tests++;
        if (total !== 16'd4 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch: got total=%0d err=%b want 4/0", total, err);
        end
    endtask

    task automatic test_jump();
        cnt_in = 3'd7;
        tick(3);
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL jump_err_early: got %b want 0", err);
        end
        tick(1);
        n_tests++;
        if (err !== 1'b1 || total !== 16'd10) begin
            n_fail++; $display("FAIL jump: got err=%b total=%0d want 1/10", err, total);
        end
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        n_tests++;
        if (err !== 1'b0 || total !== 16'd0 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL jump_clr: got err=%b total=%0d valid=%b want 0/0/1",
                     err, total, valid);
        end
    endtask

    task automatic test_hit();
        logic [2:0] seq [3] = '{3'd0, 3'd1, 3'd2};
        thr = 16'd3; thr_ld = 1'b1;
        tick(1);
        thr_ld = 1'b0;
        n_tests++;
        if (hit !== 1'b0) begin
            n_fail++; $display("FAIL hit_after_ld: got %b want 0", hit);
        end
        for (int i = 0; i < 3; i++) begin
            cnt_in = seq[i];
            tick(3);
            n_tests++;
            if (hit !== 1'b0) begin
                n_fail++; $display("FAIL hit_pre%0d: got %b want 0", i, hit);
            end
            tick(1);
            n_tests++;
            if (total !== 16'(i + 1) || hit !== (i == 2)) begin
                n_fail++;
                $display("FAIL hit_step%0d: got total=%0d hit=%b want %0d/%b",
                         i, total, hit, i + 1, (i == 2));
            end
        end
        // clr lands on the same edge the 2->3 delta is accepted
        cnt_in = 3'd3;
        tick(3);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        n_tests++;
        if (total !== 16'd0 || hit !== 1'b0) begin
            n_fail++; $display("FAIL hit_clr: got total=%0d hit=%b want 0/0", total, hit);
        end
        tick(4);
        n_tests++;
        if (total !== 16'd0) begin
            n_fail++; $display("FAIL clr_drop: got %0d want 0", total);
        end
        cnt_in = 3'd4;
        tick(4);
        n_tests++;
        if (total !== 16'd1) begin
            n_fail++; $display("FAIL clr_reseed: got %0d want 1", total);
        end
        thr = 16'd0; thr_ld = 1'b1; clr = 1'b1;
        tick(1);
        thr_ld = 1'b0; clr = 1'b0;
        n_tests++;
        if (total !== 16'd0 || hit !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_ld_same: got total=%0d hit=%b want 0/0", total, hit);
        end
        tick(1);
        n_tests++;
        if (hit !== 1'b1) begin
            n_fail++; $display("FAIL clr_ld_hit: got %b want 1", hit);
        end
    endtask

    task automatic test_reset_mid();
        nrst = 1'b0;
        tick(1);
        n_tests++;
        if ({valid, hit, ovf, err} !== 4'b0000 || total !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got v/h/o/e=%b total=%0d want 0000/0",
                     {valid, hit, ovf, err}, total);
        end
        nrst = 1'b1;
        tick(4);
        n_tests++;
        if (valid !== 1'b1 || total !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_reseed: got valid=%b total=%0d want 1/0", valid, total);
        end
        cnt_in = 3'd5;
        tick(4);
        n_tests++;
        if (total !== 16'd1 || hit !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_step: got total=%0d hit=%b want 1/0", total, hit);
        end
    endtask

    task automatic test_ovf();
        logic [2:0] v;
        v = cnt_in2;
        n_tests++;
        if (valid2 !== 1'b1 || total2 !== 4'd0) begin
            n_fail++;
            $display("FAIL ovf_start: got valid=%b total=%0d want 1/0", valid2, total2);
        end
        for (int i = 1; i <= 20; i++) begin
            v = v + 3'd1;
            cnt_in2 = v;
            tick(4);
            n_tests++;
            if (total2 !== 4'(i % 16) || ovf2 !== (i >= 16)) begin
                n_fail++;
                $display("FAIL ovf_inc%0d: got total=%0d ovf=%b want %0d/%b",
                         i, total2, ovf2, i % 16, (i >= 16));
            end
        end
        n_tests++;
        if (hit2 !== 1'b1 || err2 !== 1'b0) begin
            n_fail++; $display("FAIL ovf_flags: got hit=%b err=%b want 1/0", hit2, err2);
        end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_glitch();
        test_jump();
        test_hit();
        test_reset_mid();
        test_ovf();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
